apb_gpio_debounce_irq: RTL and testbench
========================================

// Module: apb_gpio_debounce_irq
// PURPOSE
//  Parametrised APB3 GPIO slave. Successor to the fixed-config GPIO: adds per-bit 2-flop sync, per-bit debounce,
//  runtime-programmable edge/level/both-edge interrupts, and atomic W1S/W1C output and status registers.
//  Sits on the peripheral APB segment. GPIO_IN comes from pads; GPIO_OUT/GPIO_OE drive pad buffers.
// PARAMETERS
//  IO_NUM      8     number of GPIO bits, 1..APB_WIDTH
//  APB_WIDTH   32    data bus width, one of 8/16/32
//  DB_CYCLES   16    cycles a synced input must hold a new value before it is accepted, >=1
//  OUT_RESET   0     GPIO_OUT reset value [IO_NUM-1:0]
// PORTS
//  PCLK      in   1          clock, all logic
//  PRESET    in   1          synchronous active-high reset
//  PSEL      in   1          APB select
//  PENABLE   in   1          APB access phase
//  PWRITE    in   1          1=write
//  PADDR     in   8          byte address, [1:0] ignored
//  PWDATA    in   APB_WIDTH  write data
//  PRDATA    out  APB_WIDTH  read data; 0 when not reading
//  PREADY    out  1          tied 1 (zero wait states)
//  PSLVERR   out  1          1 in access phase to an unmapped address
//  GPIO_IN   in   IO_NUM     asynchronous pad inputs
//  GPIO_OUT  out  IO_NUM     output register
//  GPIO_OE   out  IO_NUM     output enable register
//  INT       out  IO_NUM     = INT_STAT
//  INT_OR    out  1          = |INT_STAT
// BEHAVIOUR
//  Registers (bits >= IO_NUM read 0, writes ignored):
//   0x00 OE rw | 0x04 OUT rw | 0x08 OUT_SET w1s (reads OUT) | 0x0C OUT_CLR w1c (reads OUT) | 0x10 IN ro
//   0x14 INT_EN rw | 0x18 INT_EDGE rw (1=edge,0=level) | 0x1C INT_POL rw (1=rise/high,0=fall/low)
//   0x20 INT_BOTH rw (1=both edges; overrides POL when EDGE=1) | 0x24 INT_STAT r/w1c | 0x28 DB_EN rw (0=bypass)
//  APB: write commits on the PCLK edge with PSEL&PENABLE&PWRITE. Read data is combinational from registers
//   while PSEL&!PWRITE. Unmapped address: PSLVERR=1 in access phase, no state change, PRDATA=0. Writes to IN: PSLVERR=1.
//  Reset (PRESET=1 at edge): OUT=OUT_RESET; OE, INT_EN, INT_EDGE, INT_POL, INT_BOTH, INT_STAT all 0; DB_EN all 1;
//   sync flops, debounced IN and counters 0. Outputs follow their registers: GPIO_OE=0, INT=0, INT_OR=0.
//   Reset mid-transfer aborts the transfer; PSLVERR is 0 during reset.
//  Input path per bit: 2-flop sync s. With DB_EN=0: d<=s, so GPIO_IN appears at IN 3 edges later.
//   With DB_EN=1: counter cnt (width clog2(DB_CYCLES+1)). If s==d, cnt<=0. Else cnt<=cnt+1.
//   When cnt reaches DB_CYCLES-1 and s!=d, d<=s and cnt<=0. Latency is 2+DB_CYCLES edges.
//   A glitch shorter than DB_CYCLES resets cnt and is never seen. Clearing DB_EN mid-count zeroes cnt.
//  Interrupt per bit, from d and d_prev (1-cycle delayed d). set = INT_EN & cond, where cond is:
//   level (EDGE=0): d==POL
//   edge  (EDGE=1): BOTH ? d^d_prev : (POL ? d&~d_prev : ~d&d_prev)
//   INT_STAT <= (INT_STAT & ~w1c_mask) | set. Set wins over a simultaneous W1C.
//   An active level re-sets the bit every cycle, so W1C is only effective after the level drops.
//   Clearing INT_EN does not clear existing INT_STAT.
//  OUT: writes in priority order OUT (direct), then SET (OUT|=m), then CLR (OUT&=~m). Only one can occur per cycle.
// STRUCTURE
//  Package apb_gpio_pkg: register offset localparams, PSLVERR decode helper, INT mode field names.
//  Sub-module gpio_in_cond: one bit of sync+debounce+edge detect (inputs s_in, db_en; outputs d, d_prev).
//   Instantiated IO_NUM times in a generate loop. Top holds the APB decode, registers and interrupt logic.
// TESTING
//  T1 reset: PRESET 2 cycles, read all regs -> OUT=OUT_RESET, DB_EN=all ones, others 0, INT_OR=0, PSLVERR=0.
//  T2 out atomics: write OUT=0xA5, OUT_SET=0x0A, OUT_CLR=0x81 -> GPIO_OUT 0xA5,0xAF,0x2E; OE=0xFF -> GPIO_OE=0xFF.
//  T3 debounce, DB_CYCLES=16: GPIO_IN[0] 15-cycle pulse -> IN[0] stays 0; 20-cycle high -> IN[0]=1 exactly 18 edges after the rise.
//   DB_EN[0]=0 -> 3 edges.
//  T4 edge irq: EN[1]=1, EDGE[1]=1, POL[1]=1, raise IN[1] -> INT[1]=1 and INT_OR=1; W1C 0x02 -> 0.
//   BOTH[1]=1, fall -> INT[1]=1.
//  T5 level irq: EDGE[2]=0, POL[2]=0, IN[2]=0 -> W1C 0x04 leaves INT[2]=1; raise IN[2] then W1C -> INT[2]=0.
//   Simultaneous edge and W1C -> bit stays 1.
//  T6 errors: read 0x30 -> PSLVERR=1, PRDATA=0; write IN -> PSLVERR=1, no change. IO_NUM=5: write OE=0xFF -> read 0x1F.

Source files
------------

// File: rtl/apb_gpio_pkg.sv
// Shared definitions for the APB GPIO block: register map, interrupt mode encodings
// and the address error decode.
package apb_gpio_pkg;

   localparam logic [7:0] OffOe      = 8'h00;
   localparam logic [7:0] OffOut     = 8'h04;
   localparam logic [7:0] OffOutSet  = 8'h08;
   localparam logic [7:0] OffOutClr  = 8'h0C;
   localparam logic [7:0] OffIn      = 8'h10;
   localparam logic [7:0] OffIntEn   = 8'h14;
   localparam logic [7:0] OffIntEdge = 8'h18;
   localparam logic [7:0] OffIntPol  = 8'h1C;
   localparam logic [7:0] OffIntBoth = 8'h20;
   localparam logic [7:0] OffIntStat = 8'h24;
   localparam logic [7:0] OffDbEn    = 8'h28;

   typedef enum logic {
      IntLevel = 1'b0,
      IntEdge  = 1'b1
   } int_mode_e;

   typedef enum logic {
      IntFallLow  = 1'b0,
      IntRiseHigh = 1'b1
   } int_pol_e;

   // Unmapped word, or a write to the read-only input register.
   function automatic logic addr_err(input logic [7:0] addr, input logic write);
      logic [7:0] word;
      word = {addr[7:2], 2'b00};
      return (word > OffDbEn) || (write && (word == OffIn));
   endfunction

endpackage

// File: rtl/apb_gpio_debounce_irq_if.sv
// APB3 bus bundle between the peripheral segment and the GPIO slave.
interface apb_gpio_debounce_irq_if #(
   parameter int unsigned APB_WIDTH = 32
);
   logic                 PSEL;
   logic                 PENABLE;
   logic                 PWRITE;
   logic [7:0]           PADDR;
   logic [APB_WIDTH-1:0] PWDATA;
   logic [APB_WIDTH-1:0] PRDATA;
   logic                 PREADY;
   logic                 PSLVERR;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY, PSLVERR
   );
endinterface

// File: rtl/gpio_in_cond.sv
// One GPIO input bit: 2-flop synchroniser, optional debounce and a one-cycle delayed copy
// of the accepted value for edge detection.
module gpio_in_cond #(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic PCLK,
   input  logic PRESET,
   input  logic s_in,
   input  logic db_en,
   output logic d,
   output logic d_prev
);
   localparam int unsigned CntW = $clog2(DB_CYCLES + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DB_CYCLES - 1);

   logic [1:0]      sync_q;
   logic            s;
   logic            d_q, d_d, d_prev_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   assign s = sync_q[1];

   // Any cycle where the synced value matches the accepted one restarts the count.
   always_comb begin
      d_d   = d_q;
      cnt_d = '0;
      if (!db_en) begin
         d_d = s;
      end else if (s != d_q) begin
         if (cnt_q == CntLast) begin
            d_d = s;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sync_q   <= '0;
         d_q      <= 1'b0;
         d_prev_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync_q   <= {sync_q[0], s_in};
         d_q      <= d_d;
         d_prev_q <= d_q;
         cnt_q    <= cnt_d;
      end
   end

   assign d      = d_q;
   assign d_prev = d_prev_q;

endmodule

// File: rtl/apb_gpio_debounce_irq.sv
// APB3 GPIO slave: output/enable registers with atomic set/clear, debounced inputs and
// per-bit programmable level/edge interrupts.
module apb_gpio_debounce_irq
   import apb_gpio_pkg::*;
#(
   parameter int unsigned       IO_NUM    = 8,
   parameter int unsigned       APB_WIDTH = 32,
   parameter int unsigned       DB_CYCLES = 16,
   parameter logic [IO_NUM-1:0] OUT_RESET = '0
) (
   input  logic                PCLK,
   input  logic                PRESET,
   apb_gpio_debounce_irq_if.slave apb,
   input  logic [IO_NUM-1:0]   GPIO_IN,
   output logic [IO_NUM-1:0]   GPIO_OUT,
   output logic [IO_NUM-1:0]   GPIO_OE,
   output logic [IO_NUM-1:0]   INT,
   output logic                INT_OR
);
   logic [7:0]           addr_w;
   logic                 access, err, wr_en, rd_en;
   logic [IO_NUM-1:0]    wdata, w1c_mask;
   logic [IO_NUM-1:0]    in_d, in_prev, int_cond, int_set;
   logic [APB_WIDTH-1:0] rdata;
   logic                 unused_apb;

   logic [IO_NUM-1:0] oe_q, oe_d, out_q, out_d;
   logic [IO_NUM-1:0] int_en_q, int_en_d, int_edge_q, int_edge_d;
   logic [IO_NUM-1:0] int_pol_q, int_pol_d, int_both_q, int_both_d;
   logic [IO_NUM-1:0] int_stat_q, int_stat_d, db_en_q, db_en_d;

   assign addr_w = {apb.PADDR[7:2], 2'b00};
   assign access = apb.PSEL & apb.PENABLE;
   assign err    = access & ~PRESET & addr_err(apb.PADDR, apb.PWRITE);
   assign wr_en  = access & apb.PWRITE & ~err;
   assign rd_en  = apb.PSEL & ~apb.PWRITE;
   assign wdata  = apb.PWDATA[IO_NUM-1:0];

   assign unused_apb = ^apb.PWDATA;

   for (genvar i = 0; i < IO_NUM; i++) begin : g_bit
      gpio_in_cond #(
         .DB_CYCLES(DB_CYCLES)
      ) u_in_cond (
         .PCLK  (PCLK),
         .PRESET(PRESET),
         .s_in  (GPIO_IN[i]),
         .db_en (db_en_q[i]),
         .d     (in_d[i]),
         .d_prev(in_prev[i])
      );

      assign int_cond[i] = (int_edge_q[i] == IntEdge) ?
         (int_both_q[i] ? (in_d[i] ^ in_prev[i]) :
          (int_pol_q[i] == IntRiseHigh) ? (in_d[i] & ~in_prev[i]) : (~in_d[i] & in_prev[i])) :
         (in_d[i] == int_pol_q[i]);
   end

   assign int_set = int_en_q & int_cond;

   always_comb begin
      oe_d       = oe_q;
      out_d      = out_q;
      int_en_d   = int_en_q;
      int_edge_d = int_edge_q;
      int_pol_d  = int_pol_q;
      int_both_d = int_both_q;
      db_en_d    = db_en_q;
      w1c_mask   = '0;
      if (wr_en) begin
         case (addr_w)
            OffOe:      oe_d       = wdata;
            OffOut:     out_d      = wdata;
            OffOutSet:  out_d      = out_q | wdata;
            OffOutClr:  out_d      = out_q & ~wdata;
            OffIntEn:   int_en_d   = wdata;
            OffIntEdge: int_edge_d = wdata;
            OffIntPol:  int_pol_d  = wdata;
            OffIntBoth: int_both_d = wdata;
            OffIntStat: w1c_mask   = wdata;
            OffDbEn:    db_en_d    = wdata;
            default: ;
         endcase
      end
      // A new event in the same cycle outranks the clear.
      int_stat_d = (int_stat_q & ~w1c_mask) | int_set;
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         oe_q       <= '0;
         out_q      <= OUT_RESET;
         int_en_q   <= '0;
         int_edge_q <= '0;
         int_pol_q  <= '0;
         int_both_q <= '0;
         int_stat_q <= '0;
         db_en_q    <= '1;
      end else begin
         oe_q       <= oe_d;
         out_q      <= out_d;
         int_en_q   <= int_en_d;
         int_edge_q <= int_edge_d;
         int_pol_q  <= int_pol_d;
         int_both_q <= int_both_d;
         int_stat_q <= int_stat_d;
         db_en_q    <= db_en_d;
      end
   end

   always_comb begin
      rdata = '0;
      if (rd_en) begin
         case (addr_w)
            OffOe:                       rdata = APB_WIDTH'(oe_q);
            OffOut, OffOutSet, OffOutClr: rdata = APB_WIDTH'(out_q);
            OffIn:                       rdata = APB_WIDTH'(in_d);
            OffIntEn:                    rdata = APB_WIDTH'(int_en_q);
            OffIntEdge:                  rdata = APB_WIDTH'(int_edge_q);
            OffIntPol:                   rdata = APB_WIDTH'(int_pol_q);
            OffIntBoth:                  rdata = APB_WIDTH'(int_both_q);
            OffIntStat:                  rdata = APB_WIDTH'(int_stat_q);
            OffDbEn:                     rdata = APB_WIDTH'(db_en_q);
            default:                     rdata = '0;
         endcase
      end
   end

   assign apb.PRDATA  = rdata;
   assign apb.PREADY  = 1'b1;
   assign apb.PSLVERR = err;

   assign GPIO_OUT = out_q;
   assign GPIO_OE  = oe_q;
   assign INT      = int_stat_q;
   assign INT_OR   = |int_stat_q;

endmodule

// File: tb/tb_apb_gpio_debounce_irq.sv
// Bench for apb_gpio_debounce_irq: directed scenarios plus randomized APB/pad traffic checked
// against a cycle-stepped register/debounce model.
module tb_apb_gpio_debounce_irq;
   localparam int unsigned DB = 16;
   localparam logic [7:0] OUT_RST = 8'h3C;
   localparam logic [4:0] OUT_RST5 = 5'h0A;

   int n_checks = 0;
   int n_fail = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out, gpio_oe, irq;
   logic       irq_or;
   logic [4:0] gpio_in5;
   logic [4:0] gpio_out5, gpio_oe5, irq5;
   logic       irq_or5;
   logic       mon_en = 1'b0;

   apb_gpio_debounce_irq_if #(.APB_WIDTH(32)) bus ();
   apb_gpio_debounce_irq_if #(.APB_WIDTH(32)) bus5 ();

   apb_gpio_debounce_irq #(
      .IO_NUM(8), .APB_WIDTH(32), .DB_CYCLES(DB), .OUT_RESET(OUT_RST)
   ) u_dut (
      .PCLK(clk), .PRESET(rst), .apb(bus), .GPIO_IN(gpio_in), .GPIO_OUT(gpio_out),
      .GPIO_OE(gpio_oe), .INT(irq), .INT_OR(irq_or)
   );

   apb_gpio_debounce_irq #(
      .IO_NUM(5), .APB_WIDTH(32), .DB_CYCLES(3), .OUT_RESET(OUT_RST5)
   ) u_dut5 (
      .PCLK(clk), .PRESET(rst), .apb(bus5), .GPIO_IN(gpio_in5), .GPIO_OUT(gpio_out5),
      .GPIO_OE(gpio_oe5), .INT(irq5), .INT_OR(irq_or5)
   );

   // Reference model state
   logic [7:0] m_oe, m_out, m_en, m_edge, m_pol, m_both, m_stat, m_db, m_d, m_dp;
   logic [7:0] hist [0:31];

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic exp_err(input logic [7:0] addr, input logic wr);
      int word;
      word = int'(addr) / 4;
      return (word > 10) || (wr && word == 4);
   endfunction

   function automatic logic [31:0] exp_read(input logic [7:0] addr);
      case (int'(addr) / 4)
         0:       return {24'h0, m_oe};
         1, 2, 3: return {24'h0, m_out};
         4:       return {24'h0, m_d};
         5:       return {24'h0, m_en};
         6:       return {24'h0, m_edge};
         7:       return {24'h0, m_pol};
         8:       return {24'h0, m_both};
         9:       return {24'h0, m_stat};
         10:      return {24'h0, m_db};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [7:0] set_v, w1c, new_d, wd;
      logic rise, fall, stable;
      if (rst) begin
         m_oe = '0; m_out = OUT_RST; m_en = '0; m_edge = '0; m_pol = '0; m_both = '0;
         m_stat = '0; m_db = 8'hFF; m_d = '0; m_dp = '0;
         for (int k = 0; k < 32; k++) hist[k] = '0;
         return;
      end
      for (int b = 0; b < 8; b++) begin
         rise = m_d[b] & ~m_dp[b];
         fall = ~m_d[b] & m_dp[b];
         if (!m_en[b]) set_v[b] = 1'b0;
         else if (m_edge[b]) set_v[b] = m_both[b] ? (rise | fall) : (m_pol[b] ? rise : fall);
         else set_v[b] = (m_d[b] == m_pol[b]);
      end
      // hist[k] holds the pad value sampled k edges ago; the sync chain adds two edges.
      for (int k = 31; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = gpio_in;
      new_d = m_d;
      for (int b = 0; b < 8; b++) begin
         if (!m_db[b]) begin
            new_d[b] = hist[2][b];
         end else begin
            stable = 1'b1;
            for (int k = 2; k < DB + 2; k++) if (hist[k][b] == m_d[b]) stable = 1'b0;
            if (stable) new_d[b] = hist[2][b];
         end
      end
      m_dp = m_d;
      m_d = new_d;
      w1c = '0;
      if (bus.PSEL && bus.PENABLE && bus.PWRITE && !exp_err(bus.PADDR, 1'b1)) begin
         wd = bus.PWDATA[7:0];
         case (int'(bus.PADDR) / 4)
            0: m_oe = wd;
            1: m_out = wd;
            2: m_out = m_out | wd;
            3: m_out = m_out & ~wd;
            5: m_en = wd;
            6: m_edge = wd;
            7: m_pol = wd;
            8: m_both = wd;
            9: w1c = wd;
            10: m_db = wd;
            default: ;
         endcase
      end
      m_stat = (m_stat & ~w1c) | set_v;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         check_val("gpio_out", gpio_out, m_out);
         check_val("gpio_oe", gpio_oe, m_oe);
         check_val("int", irq, m_stat);
         check_val("int_or", irq_or, |m_stat);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic apb_xfer(input bit sel5, input bit wr, input logic [7:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err);
      @(negedge clk);
      if (sel5) begin
         bus5.PSEL = 1'b1; bus5.PENABLE = 1'b0; bus5.PWRITE = wr;
         bus5.PADDR = addr; bus5.PWDATA = wdata;
      end else begin
         bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
         bus.PADDR = addr; bus.PWDATA = wdata;
      end
      @(negedge clk);
      if (sel5) bus5.PENABLE = 1'b1;
      else bus.PENABLE = 1'b1;
      #1;
      rdata = sel5 ? bus5.PRDATA : bus.PRDATA;
      err = sel5 ? bus5.PSLVERR : bus.PSLVERR;
      if (!sel5) begin
         check_val("apb_prdata", rdata, wr ? 32'h0 : exp_read(addr));
         check_val("apb_pslverr", err, exp_err(addr, wr));
      end
      @(negedge clk);
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus5.PSEL = 1'b0; bus5.PENABLE = 1'b0; bus5.PWRITE = 1'b0;
   endtask

   task automatic apb_wr(input logic [7:0] addr, input logic [31:0] data);
      logic [31:0] rd;
      logic e;
      apb_xfer(1'b0, 1'b1, addr, data, rd, e);
   endtask

   task automatic apb_rd(input logic [7:0] addr, output logic [31:0] rd);
      logic e;
      apb_xfer(1'b0, 1'b0, addr, 32'h0, rd, e);
   endtask

   // Holds a setup-phase read of IN and counts edges until the pad change shows up.
   task automatic measure_in(input int bitn, input logic val, output int edges);
      @(negedge clk);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 8'h10;
      gpio_in[bitn] = val;
      edges = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         #1;
         if (bus.PRDATA[bitn] == val) begin
            edges = k;
            break;
         end
      end
      bus.PSEL = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic e;
      int edges;
      int idx;
      logic [7:0] a;
      rst = 1'b1;
      gpio_in = '0;
      gpio_in5 = '0;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
      bus5.PSEL = 1'b0; bus5.PENABLE = 1'b0; bus5.PWRITE = 1'b0; bus5.PADDR = '0;
      bus5.PWDATA = '0;

      // T1: reset
      @(negedge clk);
      bus.PSEL = 1'b1; bus.PENABLE = 1'b1; bus.PADDR = 8'h30;
      #1;
      check_val("t1_pslverr_in_reset", bus.PSLVERR, 1'b0);
      @(negedge clk);
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PADDR = 8'h00;
      rst = 1'b0;
      mon_en = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         a = 8'(i * 4);
         apb_rd(a, rd);
         check_val($sformatf("t1_reg_%02h", a), rd,
                   (i >= 1 && i <= 3) ? {24'h0, OUT_RST} : (i == 10) ? 32'hFF : 32'h0);
      end
      check_val("t1_int_or", irq_or, 1'b0);

      // T2: output atomics
      apb_wr(8'h04, 32'hA5);
      check_val("t2_out", gpio_out, 8'hA5);
      apb_wr(8'h08, 32'h0A);
      check_val("t2_out_set", gpio_out, 8'hAF);
      apb_wr(8'h0C, 32'h81);
      check_val("t2_out_clr", gpio_out, 8'h2E);
      apb_wr(8'h00, 32'hFF);
      check_val("t2_oe", gpio_oe, 8'hFF);

      // T3: debounce
      @(negedge clk);
      gpio_in[0] = 1'b1;
      repeat (15) @(negedge clk);
      gpio_in[0] = 1'b0;
      repeat (25) @(negedge clk);
      apb_rd(8'h10, rd);
      check_val("t3_glitch_hidden", rd[0], 1'b0);
      measure_in(0, 1'b1, edges);
      check_val("t3_db_rise_latency", edges, 18);
      measure_in(0, 1'b0, edges);
      check_val("t3_db_fall_latency", edges, 18);
      apb_wr(8'h28, 32'hFE);
      measure_in(0, 1'b1, edges);
      check_val("t3_bypass_latency", edges, 3);
      measure_in(0, 1'b0, edges);
      apb_wr(8'h28, 32'hFF);

      // T4: edge interrupt
      apb_wr(8'h14, 32'h02);
      apb_wr(8'h18, 32'h02);
      apb_wr(8'h1C, 32'h02);
      @(negedge clk);
      gpio_in[1] = 1'b1;
      repeat (22) @(negedge clk);
      check_val("t4_rise_int", irq[1], 1'b1);
      check_val("t4_rise_int_or", irq_or, 1'b1);
      apb_wr(8'h24, 32'h02);
      check_val("t4_w1c", irq[1], 1'b0);
      apb_wr(8'h20, 32'h02);
      gpio_in[1] = 1'b0;
      repeat (22) @(negedge clk);
      check_val("t4_both_fall", irq[1], 1'b1);
      apb_wr(8'h24, 32'h02);
      check_val("t4_w1c_2", irq[1], 1'b0);

      // T5: level interrupt and set-vs-clear
      apb_wr(8'h14, 32'h04);
      apb_wr(8'h18, 32'h02);
      apb_wr(8'h1C, 32'h02);
      repeat (3) @(negedge clk);
      check_val("t5_level_low", irq[2], 1'b1);
      apb_wr(8'h24, 32'h04);
      check_val("t5_w1c_while_active", irq[2], 1'b1);
      gpio_in[2] = 1'b1;
      repeat (22) @(negedge clk);
      apb_wr(8'h24, 32'h04);
      check_val("t5_w1c_after_drop", irq[2], 1'b0);
      apb_wr(8'h28, 32'hFB);
      apb_wr(8'h18, 32'h06);
      apb_wr(8'h1C, 32'h06);
      gpio_in[2] = 1'b0;
      repeat (5) @(negedge clk);
      apb_wr(8'h24, 32'h04);
      check_val("t5_pre_clear", irq[2], 1'b0);
      @(negedge clk);
      gpio_in[2] = 1'b1;
      @(negedge clk);
      apb_wr(8'h24, 32'h04);
      check_val("t5_set_wins", irq[2], 1'b1);
      apb_wr(8'h24, 32'h04);
      check_val("t5_clear_later", irq[2], 1'b0);

      // T6: errors and narrow instance
      apb_xfer(1'b0, 1'b0, 8'h30, 32'h0, rd, e);
      check_val("t6_unmapped_err", e, 1'b1);
      check_val("t6_unmapped_data", rd, 32'h0);
      apb_xfer(1'b0, 1'b1, 8'h10, 32'hFF, rd, e);
      check_val("t6_write_in_err", e, 1'b1);
      apb_rd(8'h10, rd);
      check_val("t6_in_unchanged", rd, {24'h0, m_d});
      apb_xfer(1'b1, 1'b1, 8'h00, 32'hFF, rd, e);
      check_val("t6_io5_wr_err", e, 1'b0);
      apb_xfer(1'b1, 1'b0, 8'h00, 32'h0, rd, e);
      check_val("t6_io5_oe_mask", rd, 32'h1F);
      check_val("t6_io5_gpio_oe", gpio_oe5, 5'h1F);
      apb_xfer(1'b1, 1'b0, 8'h04, 32'h0, rd, e);
      check_val("t6_io5_out_reset", rd, {27'h0, OUT_RST5});

      // Randomized traffic
      repeat (600) begin
         if ($urandom_range(0, 7) == 0) begin
            idx = $urandom_range(0, 7);
            gpio_in[idx] = ~gpio_in[idx];
         end
         case ($urandom_range(0, 3))
            0: repeat ($urandom_range(1, 4)) @(negedge clk);
            1: apb_rd(8'($urandom_range(0, 52)), rd);
            default: apb_wr(8'($urandom_range(0, 52)), $urandom);
         endcase
      end

      // Reset during the access phase of a write aborts it
      @(negedge clk);
      bus.PSEL = 1'b1; bus.PWRITE = 1'b1; bus.PADDR = 8'h00; bus.PWDATA = 32'h55;
      @(negedge clk);
      bus.PENABLE = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      rst = 1'b0;
      check_val("rst_abort_oe", gpio_oe, 8'h00);
      check_val("rst_abort_out", gpio_out, OUT_RST);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
